// File: rtl/data_memory_pipe.sv
// Synchronous data memory with valid/ready request port and a 1..4 stage read pipeline.
// Responses carry backpressure; out-of-range reads return zero with resp_error set.
module data_memory_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  resp_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Power-up image: words 0 and 1 carry the legacy boot constants, the rest are zero.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{0: DATA_WIDTH'(8'h48), 1: DATA_WIDTH'(8'h08), default: '0};

    logic [READ_LATENCY:1]                 vld_pipe;
    logic [READ_LATENCY:1]                 err_pipe;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    logic                  stall;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Full-width compare so high address bits never alias onto low words.
    assign in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign mem_idx  = addr[IDX_W-1:0];
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    assign stall     = resp_valid & ~resp_ready;
    assign req_ready = ~stall;
    assign accept    = req_valid & req_ready & ~reset;
    assign rd_acc    = accept & ~req_write;
    assign wr_acc    = accept & req_write;

    // Array contents survive reset; only the reset qualifier on accept blocks writes.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range)
            mem[mem_idx] <= wdata;
    end

    // Data/error registers only load behind a valid entry, so rdata holds across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) begin
                dat_pipe[1] <= rd_word;
                err_pipe[1] <= ~in_range;
            end
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                    err_pipe[i] <= err_pipe[i-1];
                end
            end
        end
    end

    assign resp_valid = vld_pipe[READ_LATENCY];
    assign rdata      = dat_pipe[READ_LATENCY];
    assign resp_error = err_pipe[READ_LATENCY];

endmodule
